// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/decode controls, IMEM port and IF/ID register outputs.
// Bit 0 is the MSB on every bus.
// master = fetch stage, slave = decode/hazard/IMEM side.
interface fetch_stage_if;
  logic        stall;
  logic        branch;
  logic [0:31] branch_target;
  logic [0:31] imem_addr;
  logic [0:31] imem_rdata;
  logic [0:31] instruction;
  logic [0:31] pc_out;
  logic [0:31] pc_plus4;
  logic        valid;
  logic        halted;

  modport master (
    input  stall, branch, branch_target, imem_rdata,
    output imem_addr, instruction, pc_out, pc_plus4, valid, halted
  );

  modport slave (
    output stall, branch, branch_target, imem_rdata,
    input  imem_addr, instruction, pc_out, pc_plus4, valid, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the IMEM address and holds the IF/ID register (FETCH_TRAP_HALT_EN adds trap halt).
// Latency: imem_addr is the PC combinationally; IMEM data reaches IF/ID one clock later.
// Backpressure: stall holds PC and IF/ID; branch overrides stall and flushes IF/ID with a bubble.
module fetch_stage #(
  parameter logic [0:31] RESET_PC  = 32'h0000_0000,
  parameter logic [0:31] NOP_WORD  = 32'h5400_0000
`ifdef FETCH_TRAP_HALT_EN
  ,
  parameter logic [0:31] TRAP_WORD = 32'h4400_0300
`endif
) (
  input logic         clock,
  input logic         reset,
  fetch_stage_if.master bus
);

  logic [0:31] pc_q, pc_d;
  logic [0:31] instr_q, instr_d;
  logic [0:31] pc_out_q, pc_out_d;
  logic [0:31] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic        halt_active;

  logic [0:31] pc_inc;
  logic [0:31] branch_pc;
  logic        unused_target_lsbs;

  // Word-aligned redirect target; PC increment wraps modulo 2^32.
  assign pc_inc             = pc_q + 32'd4;
  assign branch_pc          = {bus.branch_target[0:29], 2'b00};
  assign unused_target_lsbs = ^bus.branch_target[30:31];

`ifdef FETCH_TRAP_HALT_EN
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
  state_t state_q, state_d;

  // State register: reset always returns to RUN.
  always_ff @(posedge clock) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next state: a trap latched on an advance freezes fetch; only a redirect resumes it.
  always_comb begin
    state_d = state_q;
    if (bus.branch) begin
      state_d = RUN;
    end else if (state_q == RUN && !bus.stall && bus.imem_rdata == TRAP_WORD) begin
      state_d = HALT;
    end
  end

  // FSM outputs.
  always_comb begin
    halt_active = (state_q == HALT);
    bus.halted  = halt_active;
  end
`else
  // Without trap halt the stage never freezes.
  always_comb begin
    halt_active = 1'b0;
    bus.halted  = 1'b0;
  end
`endif

  // Next PC and IF/ID contents: branch > stall > advance; halted fetch drains to bubbles.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (bus.branch) begin
      pc_d       = branch_pc;
      instr_d    = NOP_WORD;
      pc_out_d   = '0;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (halt_active) begin
      if (!bus.stall) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
    end else if (!bus.stall) begin
      pc_d       = pc_inc;
      instr_d    = bus.imem_rdata;
      pc_out_d   = pc_q;
      pc_plus4_d = pc_inc;
      valid_d    = 1'b1;
    end
  end

  // PC and IF/ID register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_WORD;
      pc_out_q   <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  // Drive the bus.
  always_comb begin
    bus.imem_addr   = pc_q;
    bus.instruction = instr_q;
    bus.pc_out      = pc_out_q;
    bus.pc_plus4    = pc_plus4_q;
    bus.valid       = valid_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized run against a rule-level model.
// Two instances: default RESET_PC, and RESET_PC near the top of memory for wrap checks.
// Build with or without FETCH_TRAP_HALT_EN to match the RTL.
module tb_fetch_stage;
  localparam logic [31:0] NOP  = 32'h5400_0000;
  localparam logic [31:0] TRAP = 32'h4400_0300;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Word-indexed instruction memory aliased on address bits [9:2].
  logic [31:0] mem [0:255];

  fetch_stage_if ifc ();
  fetch_stage_if ifc2 ();

  fetch_stage dut (.clock(clk), .reset(rst), .bus(ifc));
  fetch_stage #(.RESET_PC(WRAP_PC)) dut2 (.clock(clk), .reset(rst), .bus(ifc2));

  always #5 clk = ~clk;

  assign ifc.imem_rdata  = mem[ifc.imem_addr[22:29]];
  assign ifc2.imem_rdata = mem[ifc2.imem_addr[22:29]];

  // Reference model state (IF/ID contents, PC, halt flag).
  logic [31:0] m_pc, m_ins, m_pco, m_pp4;
  logic        m_v, m_h;

  // Apply one clock of the stage rules to the model.
  task automatic model_clock();
    logic [31:0] fetched;
    fetched = mem[m_pc[9:2]];
    if (rst) begin
      m_pc = 32'h0; m_ins = NOP; m_pco = 0; m_pp4 = 0; m_v = 0; m_h = 0;
    end else if (ifc.branch) begin
      m_pc = {ifc.branch_target[0:29], 2'b00};
      m_ins = NOP; m_pco = 0; m_pp4 = 0; m_v = 0; m_h = 0;
    end else if (m_h) begin
      if (!ifc.stall) begin
        m_ins = NOP; m_v = 0;
      end
    end else if (!ifc.stall) begin
      m_ins = fetched; m_pco = m_pc; m_pp4 = m_pc + 32'd4; m_v = 1;
`ifdef FETCH_TRAP_HALT_EN
      if (fetched == TRAP) m_h = 1;
`endif
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; ifc.stall = 0; ifc.branch = 0; ifc.branch_target = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ifc.instruction !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", ifc.instruction, NOP); end
    checks++; if (ifc.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifc.valid); end
    checks++; if (ifc.pc_out !== 32'h0 || ifc.pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc_fields got=%h/%h exp=0/0", ifc.pc_out, ifc.pc_plus4); end
    checks++; if (ifc.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", ifc.imem_addr); end
    checks++; if (ifc.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", ifc.halted); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_ins [3];
    exp_ins[0] = mem[0]; exp_ins[1] = mem[1]; exp_ins[2] = mem[2];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ifc.instruction !== exp_ins[i]) begin errors++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, ifc.instruction, exp_ins[i]); end
      checks++; if (ifc.pc_out !== 32'(4*i) || ifc.pc_plus4 !== 32'(4*i+4)) begin errors++; $display("FAIL seq_pc[%0d] got=%h/%h exp=%h/%h", i, ifc.pc_out, ifc.pc_plus4, 4*i, 4*i+4); end
      checks++; if (ifc.valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, ifc.valid); end
    end
    checks++; if (ifc.imem_addr !== 32'h0C) begin errors++; $display("FAIL seq_addr got=%h exp=0000000c", ifc.imem_addr); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    ifc.stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ifc.instruction !== mem[1] || ifc.pc_out !== 32'h4 || ifc.imem_addr !== 32'h8) begin
        errors++; $display("FAIL stall_hold[%0d] got=%h/%h/%h exp=%h/00000004/00000008", i, ifc.instruction, ifc.pc_out, ifc.imem_addr, mem[1]);
      end
    end
    ifc.stall = 0;
    tick();
    checks++; if (ifc.instruction !== mem[2] || ifc.pc_out !== 32'h8) begin errors++; $display("FAIL stall_release got=%h/%h exp=%h/00000008", ifc.instruction, ifc.pc_out, mem[2]); end
  endtask

  task automatic test_branch();
    do_reset();
    tick();
    ifc.branch = 1; ifc.branch_target = 32'h0000_0103;
    tick();
    ifc.branch = 0;
    checks++; if (ifc.instruction !== NOP || ifc.valid !== 1'b0) begin errors++; $display("FAIL branch_flush got=%h/%b exp=%h/0", ifc.instruction, ifc.valid, NOP); end
    checks++; if (ifc.imem_addr !== 32'h100) begin errors++; $display("FAIL branch_addr got=%h exp=00000100", ifc.imem_addr); end
    tick();
    checks++; if (ifc.instruction !== mem[8'h40] || ifc.pc_out !== 32'h100 || ifc.valid !== 1'b1) begin
      errors++; $display("FAIL branch_target_fetch got=%h/%h/%b exp=%h/00000100/1", ifc.instruction, ifc.pc_out, ifc.valid, mem[8'h40]);
    end
  endtask

  task automatic test_branch_stall();
    do_reset();
    tick(); tick();
    ifc.branch = 1; ifc.stall = 1; ifc.branch_target = 32'h40;
    tick();
    ifc.branch = 0; ifc.stall = 0;
    checks++; if (ifc.imem_addr !== 32'h40 || ifc.valid !== 1'b0) begin errors++; $display("FAIL branch_stall got=%h/%b exp=00000040/0", ifc.imem_addr, ifc.valid); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    do_reset();
    checks++; if (ifc2.imem_addr !== WRAP_PC) begin errors++; $display("FAIL wrap_reset_addr got=%h exp=%h", ifc2.imem_addr, WRAP_PC); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ifc2.pc_out !== exp_pc[i] || ifc2.pc_plus4 !== exp_pc[i] + 32'd4) begin
        errors++; $display("FAIL wrap_pc[%0d] got=%h/%h exp=%h/%h", i, ifc2.pc_out, ifc2.pc_plus4, exp_pc[i], exp_pc[i] + 32'd4);
      end
    end
  endtask

  task automatic test_trap();
    logic [31:0] saved;
    saved = mem[2];
    mem[2] = TRAP;
    do_reset();
    tick(); tick(); tick();
`ifdef FETCH_TRAP_HALT_EN
    checks++; if (ifc.instruction !== TRAP || ifc.valid !== 1'b1 || ifc.halted !== 1'b1) begin
      errors++; $display("FAIL trap_latch got=%h/%b/%b exp=%h/1/1", ifc.instruction, ifc.valid, ifc.halted, TRAP);
    end
    ifc.stall = 1;
    tick();
    checks++; if (ifc.instruction !== TRAP || ifc.valid !== 1'b1) begin errors++; $display("FAIL trap_stall_hold got=%h/%b exp=%h/1", ifc.instruction, ifc.valid, TRAP); end
    ifc.stall = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ifc.instruction !== NOP || ifc.valid !== 1'b0 || ifc.imem_addr !== 32'h0C || ifc.halted !== 1'b1) begin
        errors++; $display("FAIL trap_drain[%0d] got=%h/%b/%h/%b exp=%h/0/0000000c/1", i, ifc.instruction, ifc.valid, ifc.imem_addr, ifc.halted, NOP);
      end
    end
    do_reset();
    checks++; if (ifc.halted !== 1'b0 || ifc.imem_addr !== 32'h0) begin errors++; $display("FAIL trap_reset got=%b/%h exp=0/00000000", ifc.halted, ifc.imem_addr); end
`else
    checks++; if (ifc.instruction !== TRAP || ifc.valid !== 1'b1 || ifc.halted !== 1'b0) begin
      errors++; $display("FAIL trap_plain got=%h/%b/%b exp=%h/1/0", ifc.instruction, ifc.valid, ifc.halted, TRAP);
    end
    tick();
    checks++; if (ifc.imem_addr !== 32'h10 || ifc.halted !== 1'b0) begin errors++; $display("FAIL trap_plain_addr got=%h/%b exp=00000010/0", ifc.imem_addr, ifc.halted); end
`endif
    mem[2] = saved;
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 19) == 0) ? TRAP : $urandom;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst                = ($urandom_range(0, 199) == 0);
      ifc.stall          = ($urandom_range(0, 9) < 3);
      ifc.branch         = ($urandom_range(0, 9) == 0);
      ifc.branch_target  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      tick();
      checks++;
      if (ifc.instruction !== m_ins || ifc.pc_out !== m_pco || ifc.pc_plus4 !== m_pp4 ||
          ifc.valid !== m_v || ifc.halted !== m_h || ifc.imem_addr !== m_pc) begin
        errors++;
        $display("FAIL random[%0d] got ins=%h pc=%h p4=%h v=%b h=%b a=%h exp ins=%h pc=%h p4=%h v=%b h=%b a=%h",
                 n, ifc.instruction, ifc.pc_out, ifc.pc_plus4, ifc.valid, ifc.halted, ifc.imem_addr,
                 m_ins, m_pco, m_pp4, m_v, m_h, m_pc);
      end
    end
    rst = 0; ifc.stall = 0; ifc.branch = 0;
  endtask

  initial begin
    ifc.stall = 0; ifc.branch = 0; ifc.branch_target = 0;
    ifc2.stall = 0; ifc2.branch = 0; ifc2.branch_target = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      if (mem[i] == TRAP) mem[i] = ~TRAP;
    end
    mem[0] = 32'hA000_000A; mem[1] = 32'hB000_000B; mem[2] = 32'hC000_000C; mem[8'h40] = 32'h1234_5678;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_trap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
